// File: rtl/cache_pkg.sv
// Shared cache definitions: flush FSM state encoding and default index width.
package cache_pkg;

  localparam int unsigned DEFAULT_INDEX_LENGTH = 8;

  typedef enum logic [1:0] {
    FLUSH_IDLE  = 2'd0,
    FLUSH_SWEEP = 2'd1,
    FLUSH_DONE  = 2'd2
  } flush_state_e;

endpackage

// File: rtl/valid_line_counter.sv
// Up/down occupancy counter tracking how many cache lines are currently valid.
module valid_line_counter #(
  parameter int unsigned WIDTH = 9
) (
  input  logic             clk,
  input  logic             rst_n_i,
  input  logic             inc_i,
  input  logic             dec_i,
  output logic [WIDTH-1:0] count_o
);

  always_ff @(posedge clk or negedge rst_n_i) begin
    if (!rst_n_i) begin
      count_o <= '0;
    end else if (inc_i && !dec_i) begin
      count_o <= count_o + WIDTH'(1);
    end else if (dec_i && !inc_i) begin
      count_o <= count_o - WIDTH'(1);
    end
  end

endmodule

// File: rtl/valid_flush_engine.sv
// Valid-bit array for the direct-mapped cache with single-line invalidate and a full flush sweep.
// Optional VALID_COUNT_EN adds valid_count_o, the number of currently valid lines.
module valid_flush_engine #(
  parameter int unsigned INDEX_LENGTH = cache_pkg::DEFAULT_INDEX_LENGTH,
  parameter int unsigned CACHE_LINES  = 2**INDEX_LENGTH
) (
  input  logic                    clk,
  input  logic                    rst_n_i,
  input  logic [INDEX_LENGTH-1:0] index_i,
  input  logic                    we_i,
  input  logic                    inv_i,
  output logic                    valid_o,
  input  logic                    flush_req_i,
  output logic                    flush_busy_o,
  output logic                    flush_done_o,
  output logic [INDEX_LENGTH-1:0] flush_idx_o
`ifdef VALID_COUNT_EN
  ,
  output logic [INDEX_LENGTH:0]   valid_count_o
`endif
);

  import cache_pkg::*;

  localparam logic [INDEX_LENGTH-1:0] LAST_LINE = INDEX_LENGTH'(CACHE_LINES - 1);

  flush_state_e            state_q, state_d;
  logic [INDEX_LENGTH-1:0] ptr_q, ptr_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic [CACHE_LINES-1:0]  valid_q, valid_d;

  // State, pointer, flags and array registers
  always_ff @(posedge clk or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= FLUSH_IDLE;
      ptr_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      valid_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      valid_q <= valid_d;
    end
  end

  // Next-state logic; set/invalidate only take effect in IDLE, invalidate applied last so it wins
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    valid_d = valid_q;
    unique case (state_q)
      FLUSH_IDLE: begin
        if (we_i)  valid_d[index_i] = 1'b1;
        if (inv_i) valid_d[index_i] = 1'b0;
        if (flush_req_i) begin
          state_d = FLUSH_SWEEP;
          ptr_d   = '0;
          busy_d  = 1'b1;
        end
      end
      FLUSH_SWEEP: begin
        valid_d[ptr_q] = 1'b0;
        if (ptr_q == LAST_LINE) begin
          state_d = FLUSH_DONE;
          ptr_d   = '0;
          done_d  = 1'b1;
        end else begin
          ptr_d = ptr_q + INDEX_LENGTH'(1);
        end
      end
      FLUSH_DONE: begin
        state_d = FLUSH_IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = FLUSH_IDLE;
        ptr_d   = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign valid_o      = ~busy_q & valid_q[index_i];
  assign flush_busy_o = busy_q;
  assign flush_done_o = done_q;
  assign flush_idx_o  = ptr_q;

`ifdef VALID_COUNT_EN
  logic cnt_inc_c;
  logic cnt_dec_c;

  // Only real transitions of a bit move the count
  assign cnt_inc_c = (state_q == FLUSH_IDLE) & we_i & ~inv_i & ~valid_q[index_i];
  assign cnt_dec_c = ((state_q == FLUSH_IDLE) & inv_i & valid_q[index_i])
                   | ((state_q == FLUSH_SWEEP) & valid_q[ptr_q]);

  valid_line_counter #(
    .WIDTH (INDEX_LENGTH + 1)
  ) u_valid_line_counter (
    .clk     (clk),
    .rst_n_i (rst_n_i),
    .inc_i   (cnt_inc_c),
    .dec_i   (cnt_dec_c),
    .count_o (valid_count_o)
  );
`endif

endmodule

// File: tb/tb_valid_flush_engine.sv
// Self-checking bench for valid_flush_engine against a line-level behavioural model.
// Honours VALID_COUNT_EN when defined.
module tb_valid_flush_engine;

  localparam int unsigned IL    = 8;
  localparam int unsigned LINES = 256;

  logic          clk = 1'b0;
  logic          rst_n_i;
  logic [IL-1:0] index_i;
  logic          we_i;
  logic          inv_i;
  logic          valid_o;
  logic          flush_req_i;
  logic          flush_busy_o;
  logic          flush_done_o;
  logic [IL-1:0] flush_idx_o;
`ifdef VALID_COUNT_EN
  logic [IL:0]   valid_count_o;
`endif

  always #5 clk = ~clk;

  valid_flush_engine #(.INDEX_LENGTH(IL), .CACHE_LINES(LINES)) dut (
    .clk          (clk),
    .rst_n_i      (rst_n_i),
    .index_i      (index_i),
    .we_i         (we_i),
    .inv_i        (inv_i),
    .valid_o      (valid_o),
    .flush_req_i  (flush_req_i),
    .flush_busy_o (flush_busy_o),
    .flush_done_o (flush_done_o),
    .flush_idx_o  (flush_idx_o)
`ifdef VALID_COUNT_EN
    ,
    .valid_count_o(valid_count_o)
`endif
  );

  // Model: set of valid lines plus remaining busy cycles of the current flush
  bit model_valid [LINES];
  int busy_left;
  int total = 0;
  int bad   = 0;

  function automatic logic e_busy();
    return busy_left > 0;
  endfunction

  function automatic logic e_done();
    return busy_left == 1;
  endfunction

  function automatic logic [IL-1:0] e_idx();
    if (busy_left >= 2) return IL'(LINES + 1 - busy_left);
    return '0;
  endfunction

  function automatic logic e_valid();
    if (busy_left > 0) return 1'b0;
    return model_valid[index_i];
  endfunction

  function automatic int e_count();
    int n = 0;
    foreach (model_valid[i]) n += int'(model_valid[i]);
    return n;
  endfunction

  task automatic model_clear();
    foreach (model_valid[i]) model_valid[i] = 1'b0;
  endtask

  task automatic drive(input logic we, input logic inv, input logic [IL-1:0] idx, input logic req);
    we_i = we; inv_i = inv; index_i = idx; flush_req_i = req;
  endtask

  // Advance one clock and apply the behavioural rules to the model
  task automatic tick();
    @(posedge clk);
    if (rst_n_i) begin
      if (busy_left > 0) begin
        busy_left--;
      end else begin
        if (we_i)  model_valid[index_i] = 1'b1;
        if (inv_i) model_valid[index_i] = 1'b0;
        if (flush_req_i) begin
          busy_left = LINES + 1;
          model_clear();
        end
      end
    end
    #1;
  endtask

  task automatic test_reset();
    rst_n_i = 1'b0;
    drive(1'b0, 1'b0, IL'(5), 1'b0);
    busy_left = 0;
    model_clear();
    #12;
    total++; if (flush_busy_o !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", flush_busy_o); end
    total++; if (flush_done_o !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", flush_done_o); end
    total++; if (flush_idx_o !== '0) begin bad++; $display("FAIL reset_idx got=%0d exp=0", flush_idx_o); end
    total++; if (valid_o !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", valid_o); end
`ifdef VALID_COUNT_EN
    total++; if (valid_count_o !== '0) begin bad++; $display("FAIL reset_count got=%0d exp=0", valid_count_o); end
`endif
    rst_n_i = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_set_lookup();
    drive(1'b1, 1'b0, IL'(5), 1'b0);
    @(negedge clk);
    total++; if (valid_o !== 1'b0) begin bad++; $display("FAIL set_no_bypass got=%b exp=0", valid_o); end
    tick();
    drive(1'b0, 1'b0, IL'(5), 1'b0);
    @(negedge clk);
    total++; if (valid_o !== 1'b1) begin bad++; $display("FAIL set_lookup5 got=%b exp=1", valid_o); end
    tick();
    drive(1'b0, 1'b0, IL'(6), 1'b0);
    @(negedge clk);
    total++; if (valid_o !== 1'b0) begin bad++; $display("FAIL set_lookup6 got=%b exp=0", valid_o); end
    tick();
    drive(1'b0, 1'b1, IL'(5), 1'b0);
    tick();
  endtask

  task automatic test_inv_priority();
    drive(1'b1, 1'b0, IL'(3), 1'b0); tick();
    drive(1'b1, 1'b0, IL'(3), 1'b0); tick();
    drive(1'b0, 1'b1, IL'(4), 1'b0);
    @(negedge clk);
    total++; if (valid_o !== 1'b0) begin bad++; $display("FAIL inv_lookup4 got=%b exp=0", valid_o); end
`ifdef VALID_COUNT_EN
    total++; if (valid_count_o !== (IL+1)'(1)) begin bad++; $display("FAIL inv_count_before got=%0d exp=1", valid_count_o); end
`endif
    tick();
    drive(1'b1, 1'b1, IL'(3), 1'b0);
    @(negedge clk);
    total++; if (valid_o !== 1'b1) begin bad++; $display("FAIL inv_pre got=%b exp=1", valid_o); end
    tick();
    drive(1'b0, 1'b0, IL'(3), 1'b0);
    @(negedge clk);
    total++; if (valid_o !== 1'b0) begin bad++; $display("FAIL inv_wins got=%b exp=0", valid_o); end
`ifdef VALID_COUNT_EN
    total++; if (valid_count_o !== '0) begin bad++; $display("FAIL inv_count_after got=%0d exp=0", valid_count_o); end
`endif
    tick();
  endtask

  task automatic test_flush();
    int busy_cycles = 0;
    int done_at = -1;
    logic [IL-1:0] lines [4];
    lines[0] = IL'(0); lines[1] = IL'(7); lines[2] = IL'(255); lines[3] = IL'(200);
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 1'b0, lines[k], 1'b0); tick();
    end
`ifdef VALID_COUNT_EN
    total++; if (int'(valid_count_o) != 3) begin bad++; $display("FAIL flush_count_before got=%0d exp=3", valid_count_o); end
`endif
    drive(1'b0, 1'b0, IL'(7), 1'b1);
    @(negedge clk);
    total++; if (flush_busy_o !== 1'b0) begin bad++; $display("FAIL flush_req_cycle_busy got=%b exp=0", flush_busy_o); end
    tick();
    for (int c = 1; c <= 300 && busy_left > 0; c++) begin
      if (busy_left >= 2 && e_idx() == IL'(10)) drive(1'b1, 1'b0, IL'(200), 1'b0);
      else drive(1'b0, 1'b0, IL'(c), 1'b0);
      @(negedge clk);
      total++; if (flush_busy_o !== e_busy()) begin bad++; $display("FAIL flush_busy c=%0d got=%b exp=%b", c, flush_busy_o, e_busy()); end
      total++; if (flush_done_o !== e_done()) begin bad++; $display("FAIL flush_done c=%0d got=%b exp=%b", c, flush_done_o, e_done()); end
      total++; if (flush_idx_o !== e_idx()) begin bad++; $display("FAIL flush_idx c=%0d got=%0d exp=%0d", c, flush_idx_o, e_idx()); end
      total++; if (valid_o !== 1'b0) begin bad++; $display("FAIL flush_valid_forced c=%0d got=%b exp=0", c, valid_o); end
      if (flush_busy_o === 1'b1) busy_cycles++;
      if (flush_done_o === 1'b1) done_at = c;
      tick();
    end
    total++; if (busy_cycles != LINES + 1) begin bad++; $display("FAIL flush_busy_len got=%0d exp=%0d", busy_cycles, LINES + 1); end
    total++; if (done_at != LINES + 1) begin bad++; $display("FAIL flush_done_cycle got=%0d exp=%0d", done_at, LINES + 1); end
    for (int k = 0; k < 4; k++) begin
      drive(1'b0, 1'b0, lines[k], 1'b0);
      @(negedge clk);
      total++; if (valid_o !== 1'b0) begin bad++; $display("FAIL flush_after_lookup idx=%0d got=%b exp=0", lines[k], valid_o); end
      tick();
    end
`ifdef VALID_COUNT_EN
    total++; if (valid_count_o !== '0) begin bad++; $display("FAIL flush_count_after got=%0d exp=0", valid_count_o); end
`endif
  endtask

  task automatic test_reset_mid_sweep();
    int dones = 0;
    int busies = 0;
    drive(1'b1, 1'b0, IL'(9), 1'b0); tick();
    drive(1'b0, 1'b0, IL'(9), 1'b1); tick();
    drive(1'b0, 1'b0, IL'(9), 1'b0);
    for (int c = 0; c < 150 && e_idx() != IL'(100); c++) tick();
    @(negedge clk);
    total++; if (flush_idx_o !== IL'(100)) begin bad++; $display("FAIL rst_mid_ptr got=%0d exp=100", flush_idx_o); end
    rst_n_i = 1'b0;
    busy_left = 0;
    model_clear();
    #1;
    total++; if (flush_busy_o !== 1'b0) begin bad++; $display("FAIL rst_mid_busy got=%b exp=0", flush_busy_o); end
    total++; if (flush_done_o !== 1'b0) begin bad++; $display("FAIL rst_mid_done got=%b exp=0", flush_done_o); end
    total++; if (flush_idx_o !== '0) begin bad++; $display("FAIL rst_mid_idx got=%0d exp=0", flush_idx_o); end
    tick();
    tick();
    rst_n_i = 1'b1;
    for (int c = 0; c < 300; c++) begin
      drive(1'b0, 1'b0, IL'(9), 1'b0);
      @(negedge clk);
      if (c == 0) begin
        total++; if (valid_o !== 1'b0) begin bad++; $display("FAIL rst_mid_line9 got=%b exp=0", valid_o); end
      end
      if (flush_done_o === 1'b1) dones++;
      if (flush_busy_o === 1'b1) busies++;
      tick();
    end
    total++; if (dones != 0) begin bad++; $display("FAIL rst_mid_no_done got=%0d exp=0", dones); end
    total++; if (busies != 0) begin bad++; $display("FAIL rst_mid_no_busy got=%0d exp=0", busies); end
  endtask

  task automatic test_back_to_back();
    int dones = 0;
    int first_done = -1;
    int second_rise = -1;
    logic prev_busy = 1'b0;
    for (int c = 0; c < 540; c++) begin
      drive(1'b0, 1'b0, IL'($urandom_range(0, LINES - 1)), 1'b1);
      @(negedge clk);
      total++; if (flush_busy_o !== e_busy()) begin bad++; $display("FAIL b2b_busy c=%0d got=%b exp=%b", c, flush_busy_o, e_busy()); end
      total++; if (flush_done_o !== e_done()) begin bad++; $display("FAIL b2b_done c=%0d got=%b exp=%b", c, flush_done_o, e_done()); end
      if (flush_done_o === 1'b1) begin
        dones++;
        if (first_done < 0) first_done = c;
      end
      if (flush_busy_o === 1'b1 && !prev_busy && first_done >= 0 && second_rise < 0) second_rise = c;
      prev_busy = flush_busy_o;
      tick();
    end
    total++; if (dones != 2) begin bad++; $display("FAIL b2b_done_count got=%0d exp=2", dones); end
    total++; if (second_rise - first_done - 1 != 1) begin bad++; $display("FAIL b2b_idle_gap got=%0d exp=1", second_rise - first_done - 1); end
    drive(1'b0, 1'b0, '0, 1'b0);
    for (int c = 0; c < 300 && busy_left > 0; c++) tick();
    total++; if (busy_left != 0) begin bad++; $display("FAIL b2b_drain_timeout left=%0d exp=0", busy_left); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0),
            IL'($urandom_range(0, 15) + ($urandom_range(0, 7) == 0 ? 240 : 0)),
            1'($urandom_range(0, 79) == 0));
      @(negedge clk);
      total++; if (valid_o !== e_valid()) begin bad++; $display("FAIL rnd_valid c=%0d idx=%0d got=%b exp=%b", c, index_i, valid_o, e_valid()); end
      total++; if (flush_busy_o !== e_busy()) begin bad++; $display("FAIL rnd_busy c=%0d got=%b exp=%b", c, flush_busy_o, e_busy()); end
      total++; if (flush_done_o !== e_done()) begin bad++; $display("FAIL rnd_done c=%0d got=%b exp=%b", c, flush_done_o, e_done()); end
      total++; if (flush_idx_o !== e_idx()) begin bad++; $display("FAIL rnd_idx c=%0d got=%0d exp=%0d", c, flush_idx_o, e_idx()); end
`ifdef VALID_COUNT_EN
      if (busy_left == 0) begin
        total++; if (int'(valid_count_o) != e_count()) begin bad++; $display("FAIL rnd_count c=%0d got=%0d exp=%0d", c, valid_count_o, e_count()); end
      end
`endif
      tick();
    end
    drive(1'b0, 1'b0, '0, 1'b0);
    for (int c = 0; c < 300 && busy_left > 0; c++) tick();
  endtask

  initial begin
    test_reset();
    test_set_lookup();
    test_inv_priority();
    test_flush();
    test_reset_mid_sweep();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
